// File: rtl/pps_cond_pkg.sv
// rtl/pps_cond_pkg.sv - shared state encoding and default timing for the PPS conditioner
package pps_cond_pkg;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_HOLDOVER = 2'd3;

  localparam int NOMINAL_DEF = 200;
  localparam int TOL_DEF     = 4;

endpackage

// File: rtl/pps_sync_edge.sv
// rtl/pps_sync_edge.sv - pps_in synchroniser, glitch filter (PPS_GLITCH_FILTER_EN) and rising-edge detect
module pps_sync_edge
  import pps_cond_pkg::*;
`ifdef PPS_GLITCH_FILTER_EN
#(
  parameter int FILT_N = 3
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic pps_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic level;
  logic level_d;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pps_in;
      s2 <= s1;
    end
  end

`ifdef PPS_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_N + 1);

  logic          filt;
  logic [FW-1:0] fcnt;

  // Filtered level follows s2 only after FILT_N consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_N - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = s2;
`endif

  // Delayed copy of the level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/pps_conditioner.sv
// rtl/pps_conditioner.sv - PPS lock/holdover conditioner with pulse stretcher (option PPS_GLITCH_FILTER_EN)
module pps_conditioner
  import pps_cond_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int NOMINAL  = NOMINAL_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_N   = 3,
  parameter int MAX_MISS = 4,
  parameter int PULSE_W  = 8
`ifdef PPS_GLITCH_FILTER_EN
  ,
  parameter int FILT_N   = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps_in,
  output logic             pps_out,
  output logic             locked,
  output logic             holdover,
  output logic [CNT_W-1:0] period
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam int WW = $clog2(PULSE_W + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] CNT_NOM = CNT_W'(NOMINAL);
  localparam logic [CNT_W-1:0] CNT_TOL = CNT_W'(TOL);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_N - 1);
  localparam logic [MW-1:0]    MISS_LAST = MW'(MAX_MISS);

  logic             rise;
  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] period_nx;
  logic [GW-1:0]    good, good_nx;
  logic [MW-1:0]    miss, miss_nx;
  logic [WW-1:0]    wcnt;
  logic             emit;
  logic             in_tol;

`ifdef PPS_GLITCH_FILTER_EN
  pps_sync_edge #(.FILT_N(FILT_N)) u_sync (
`else
  pps_sync_edge u_sync (
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .pps_in (pps_in),
    .rise   (rise)
  );

  assign in_tol = (cnt >= CNT_LO) && (cnt <= CNT_HI);

  // Next-state, counter restarts and pulse requests for the lock FSM
  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt == '1) ? cnt : cnt + 1'b1;
    period_nx = period;
    good_nx   = good;
    miss_nx   = miss;
    emit      = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (rise) begin
          state_nx = ST_ACQUIRE;
          cnt_nx   = CNT_ONE;
          good_nx  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (rise) begin
          cnt_nx = CNT_ONE;
          if (in_tol) begin
            period_nx = cnt;
            good_nx   = good + 1'b1;
            if (good == GOOD_LAST) begin
              state_nx = ST_LOCKED;
              emit     = 1'b1;
            end
          end else begin
            good_nx = '0;
          end
        end else if (cnt > CNT_HI) begin
          state_nx = ST_UNLOCKED;
          good_nx  = '0;
        end
      end
      ST_LOCKED: begin
        // Early edges are glitches: the period keeps running from the last good edge
        if (rise) begin
          if (in_tol) begin
            emit      = 1'b1;
            period_nx = cnt;
            cnt_nx    = CNT_ONE;
          end
        end else if (cnt >= CNT_HI) begin
          state_nx = ST_HOLDOVER;
          emit     = 1'b1;
          cnt_nx   = CNT_ONE;
          miss_nx  = MW'(1);
        end
      end
      default: begin
        // Holdover: a real edge just after a synthetic pulse is absorbed into it
        if (rise) begin
          state_nx = ST_LOCKED;
          cnt_nx   = CNT_ONE;
          miss_nx  = '0;
          emit     = (cnt > CNT_TOL);
        end else if (cnt >= CNT_NOM) begin
          if (miss == MISS_LAST) begin
            state_nx = ST_UNLOCKED;
            good_nx  = '0;
            miss_nx  = '0;
          end else begin
            emit    = 1'b1;
            cnt_nx  = CNT_ONE;
            miss_nx = miss + 1'b1;
          end
        end
      end
    endcase
  end

  // FSM and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_UNLOCKED;
      cnt    <= '0;
      period <= '0;
      good   <= '0;
      miss   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      period <= period_nx;
      good   <= good_nx;
      miss   <= miss_nx;
    end
  end

  // Pulse stretcher: a new pulse reloads the width so back-to-back pulses merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (emit) begin
      wcnt <= WW'(PULSE_W);
    end else if (wcnt != '0) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  assign pps_out  = (wcnt != '0);
  assign locked   = (state == ST_LOCKED);
  assign holdover = (state == ST_HOLDOVER);

endmodule

// File: tb/tb_pps_conditioner.sv
// tb/tb_pps_conditioner.sv - directed self-checking bench for pps_conditioner
module tb_pps_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps_in = 1'b0;
  logic        pps_out;
  logic        locked;
  logic        holdover;
  logic [15:0] period;

  int checks = 0;
  int errors = 0;
  logic o3, o10, o11;

  pps_conditioner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pps_in   (pps_in),
    .pps_out  (pps_out),
    .locked   (locked),
    .holdover (holdover),
    .period   (period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise the pin gap cycles after the previous raise, then sample pps_out
  // 3, 10 and 11 cycles after the raise (start, last high, first low of a pulse).
  task automatic send(input int gap, output logic s3, output logic s10, output logic s11);
    repeat (gap - 11) @(negedge clk);
    pps_in = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 3) begin
        s3 = pps_out;
        pps_in = 1'b0;
      end
      if (i == 10) s10 = pps_out;
      if (i == 11) s11 = pps_out;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pps_out", pps_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_holdover", holdover, 0);
    chk("rst_period", period, 0);
    rst_n = 1'b1;

    // Lock on four edges 200 cycles apart
    send(20, o3, o10, o11);  chk("lock_e1_pulse", o3, 0);
    send(200, o3, o10, o11); chk("lock_e2_pulse", o3, 0);
    send(200, o3, o10, o11); chk("lock_e3_pulse", o3, 0);
    chk("lock_e3_locked", locked, 0);
    send(200, o3, o10, o11); chk("lock_e4_pulse", o3, 1);
    chk("lock_e4_width_last", o10, 1);
    chk("lock_e4_width_end", o11, 0);
    chk("lock_e4_locked", locked, 1);
    chk("lock_e4_period", period, 200);

    // Tolerance edges; 204 coincides with the timeout and the edge wins
    send(196, o3, o10, o11); chk("tol196_pulse", o3, 1);
    chk("tol196_period", period, 196);
    send(204, o3, o10, o11); chk("tol204_pulse", o3, 1);
    chk("tol204_period", period, 204);
    chk("tol204_locked", locked, 1);

    // Glitch at cnt=50 is ignored, following edge at cnt=200 accepted
    send(50, o3, o10, o11);  chk("glitch_pulse", o3, 0);
    chk("glitch_period", period, 204);
    chk("glitch_locked", locked, 1);
    send(150, o3, o10, o11); chk("after_glitch_pulse", o3, 1);
    chk("after_glitch_period", period, 200);

    // Holdover: edges stop
    repeat (195) @(negedge clk);
    chk("pre_hold_holdover", holdover, 0);
    chk("pre_hold_pps", pps_out, 0);
    @(negedge clk);
    chk("hold1_holdover", holdover, 1);
    chk("hold1_locked", locked, 0);
    chk("hold1_pps", pps_out, 1);
    for (int i = 0; i < 3; i++) begin
      repeat (200) @(negedge clk);
      chk("holdn_pps", pps_out, 1);
      chk("holdn_holdover", holdover, 1);
    end
    repeat (199) @(negedge clk);
    chk("hold_last_holdover", holdover, 1);
    chk("hold_last_pps", pps_out, 0);
    @(negedge clk);
    chk("unlock_holdover", holdover, 0);
    chk("unlock_locked", locked, 0);
    chk("unlock_pps", pps_out, 0);
    chk("unlock_period", period, 200);
    repeat (300) @(negedge clk);
    chk("unlock_quiet_pps", pps_out, 0);

    // Re-lock, with an out-of-tolerance edge restarting acquisition
    send(20, o3, o10, o11);  chk("relock_e1_pulse", o3, 0);
    send(190, o3, o10, o11); chk("relock_bad_pulse", o3, 0);
    send(200, o3, o10, o11); chk("relock_g1_pulse", o3, 0);
    send(200, o3, o10, o11); chk("relock_g2_pulse", o3, 0);
    chk("relock_g2_locked", locked, 0);
    send(200, o3, o10, o11); chk("relock_g3_pulse", o3, 1);
    chk("relock_g3_locked", locked, 1);

    // Holdover then resync at cnt=120
    repeat (196) @(negedge clk);
    chk("resync_hold", holdover, 1);
    send(128, o3, o10, o11); chk("resync_pulse", o3, 1);
    chk("resync_locked", locked, 1);
    chk("resync_holdover", holdover, 0);
    chk("resync_period", period, 200);

    // Holdover then edge at cnt=3: absorbed, no second pulse
    repeat (196) @(negedge clk);
    chk("absorb_hold", holdover, 1);
    send(11, o3, o10, o11);
    chk("absorb_synth_on", o3, 1);
    chk("absorb_no_extra", o10, 0);
    chk("absorb_locked", locked, 1);

    // Reset in the middle of a stretched pulse
    repeat (189) @(negedge clk);
    pps_in = 1'b1;
    repeat (3) @(negedge clk);
    pps_in = 1'b0;
    chk("midrst_pulse_on", pps_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pps", pps_out, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_period", period, 0);
    chk("midrst_holdover", holdover, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Re-lock after reset needs four edges again
    send(20, o3, o10, o11);  chk("rstlock_e1_pulse", o3, 0);
    send(200, o3, o10, o11); chk("rstlock_e2_pulse", o3, 0);
    send(200, o3, o10, o11); chk("rstlock_e3_pulse", o3, 0);
    chk("rstlock_e3_locked", locked, 0);
    send(200, o3, o10, o11); chk("rstlock_e4_pulse", o3, 1);
    chk("rstlock_e4_locked", locked, 1);
    chk("rstlock_e4_period", period, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
